xbar_xfer_ctrl: RTL
===================

Name: xbar_xfer_ctrl

Overview:
Per-input packet transfer sequencer for the 4-port switch crossbar.
- Latches each input's head-of-line packet (destination mask, beat length) and presents requests to the round-robin output arbiter.
- On grant, locks the granted outputs for the whole multi-beat packet and pops beats from the input buffer.
- Releases the locks after the last beat, so the arbiter never reassigns an output mid-packet.

Parameters:
NUM_PORTS, 4, number of input and output ports
LEN_WIDTH, 8, width of packet beat-count field
MAX_WAIT, 255, request-wait cycles before starvation flag asserts

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  NUM_PORTS  head packet present at input i
in_dst  in  NUM_PORTS*NUM_PORTS  one-hot/multicast output mask; slice i = input i
in_len  in  NUM_PORTS*LEN_WIDTH  beat count of head packet; slice i = input i
arb_req  out  NUM_PORTS  request to arbiter
arb_dst  out  NUM_PORTS*NUM_PORTS  latched destination masks to arbiter
arb_grant  in  NUM_PORTS  all-or-nothing grant from arbiter (same-cycle response to arb_req)
in_pop  out  NUM_PORTS  one pulse per beat consumed (header discard included)
out_busy  out  NUM_PORTS  output j locked by an active transfer
xfer_done  out  NUM_PORTS  1-cycle pulse on last beat of input i
err_drop  out  NUM_PORTS  1-cycle pulse when a malformed head is discarded
starve  out  NUM_PORTS  input i waited >= MAX_WAIT cycles in REQ

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values:
  - all FSMs in IDLE, counters 0, locks 0.
  - arb_req, arb_dst, in_pop, out_busy, xfer_done, err_drop and starve all 0.
  - Reset mid-transfer aborts immediately; no done pulse is issued.
- Per-input FSM with states IDLE, REQ, XFER.
- IDLE:
  - If in_valid[i] && dst!=0 && len!=0: latch dst and len, go to REQ next cycle.
  - If in_valid[i] && (dst==0 || len==0): pulse in_pop[i] and err_drop[i] for 1 cycle, stay IDLE.
- REQ:
  - arb_req[i] = 1 only when (latched_dst & lock_vec) == 0; arb_req is combinational from state and lock_vec.
  - arb_dst slice i = latched dst while in REQ, else 0.
  - wait_cnt increments each REQ cycle, saturating at MAX_WAIT. starve[i] = (wait_cnt == MAX_WAIT).
  - On arb_req[i] && arb_grant[i]: go to XFER next cycle; lock_vec |= latched_dst (registered); beat_cnt = len; wait_cnt cleared.
  - arb_grant[i] while arb_req[i] is low is ignored.
- XFER:
  - in_pop[i] = 1 every cycle.
  - beat_cnt decrements by 1 per cycle.
  - When beat_cnt == 1: xfer_done[i] = 1, clear latched_dst bits from lock_vec at the clock edge, go to IDLE.
- Latency:
  - Packet of length L: grant at cycle g, pops on cycles g+1 .. g+L, done on cycle g+L.
  - Outputs are free on cycle g+L+1.
  - Earliest next head acceptance is IDLE at g+L+1, REQ at g+L+2.
- out_busy = lock_vec (registered).
- Simultaneous events:
  - Release and new grant of the same output in one cycle: the new grant cannot occur, because the lock is still set that cycle.
  - Two grants with overlapping masks in the same cycle are an arbiter fault. Grants are honored in ascending index order; a later overlapping grant is ignored, its input stays in REQ and is flagged on err_drop.
- len == 2^LEN_WIDTH-1 is legal; the counter must not wrap.

Optional Feature:
XBAR_XFER_STATS_EN
- Defined: adds output pkt_count (NUM_PORTS*16), a per-input 16-bit wrap-around count of completed packets, incremented on xfer_done. Also adds input stats_clr, a synchronous clear that takes priority over the increment.
- Undefined: the pkt_count and stats_clr ports and their counters are absent.

Decomposition:
- switch package (packet_pkg): NUM_PORTS, LEN_WIDTH default, and typedef xfer_state_e {IDLE, REQ, XFER}.
- Sub-module xfer_port_fsm: one FSM plus its beat and wait counters, instantiated NUM_PORTS times.
- Top level owns lock_vec, grant ordering and the optional stats.

Test Plan:
1. in0 dst=0010 len=3, arb_grant tied to arb_req -> req on cycle 2, in_pop[0] cycles 3-5, xfer_done[0] cycle 5, out_busy[1] high cycles 3-5.
2. in0 dst=0011 len=4 locked; in1 dst=0010 valid -> arb_req[1]=0 until out_busy[1] clears, then granted; no overlap of out_busy ownership.
3. in2 dst=0000 len=5 -> single in_pop[2] and err_drop[2] pulse, no arb_req[2]; same for dst=0100 len=0.
4. in3 held in REQ with arb_grant[3]=0 for 300 cycles, MAX_WAIT=255 -> starve[3] rises on the 255th REQ cycle, clears on grant.
5. rst asserted mid-XFER of len=10 after 4 beats -> all outputs 0 the next cycle, no xfer_done; a fresh packet then completes normally.
6. XBAR_XFER_STATS_EN: 3 packets on in1 -> pkt_count[1]=3; stats_clr asserted in the same cycle as xfer_done -> count 0.

Source files
------------

// File: rtl/packet_pkg.sv
// packet_pkg: shared switch constants and per-input transfer state encoding
package packet_pkg;
    localparam int NUM_PORTS = 4;
    localparam int LEN_WIDTH = 8;
    localparam int MAX_WAIT  = 255;
    typedef enum logic [1:0] {IDLE, REQ, XFER} xfer_state_e;
endpackage

// File: rtl/xfer_port_fsm.sv
// xfer_port_fsm: per-input head latch, arbiter request and beat sequencer
module xfer_port_fsm #(
    parameter int NUM_PORTS = 4,
    parameter int LEN_WIDTH = 8,
    parameter int MAX_WAIT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [NUM_PORTS-1:0] dst,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [NUM_PORTS-1:0] lock_vec,
    input  logic                 grant,
    output logic                 req,
    output logic [NUM_PORTS-1:0] req_dst,
    output logic [NUM_PORTS-1:0] held_dst,
    output logic                 pop,
    output logic                 done,
    output logic                 drop,
    output logic                 starve
);
    import packet_pkg::*;
    localparam int WW = $clog2(MAX_WAIT + 1);
    xfer_state_e          state;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [WW-1:0]        wait_cnt;
    // wait_cnt counts the current REQ cycle, so starve rises on the MAX_WAIT-th one
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            held_dst <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (valid && |dst && |len) begin
                    held_dst <= dst;
                    beat_cnt <= len;
                    wait_cnt <= WW'(1);
                    state    <= REQ;
                end
                REQ: if (grant) begin
                    wait_cnt <= '0;
                    state    <= XFER;
                end else if (wait_cnt != WW'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                XFER: begin
                    beat_cnt <= beat_cnt - 1'b1;
                    if (beat_cnt == LEN_WIDTH'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign req     = (state == REQ) && ~|(held_dst & lock_vec);
    assign req_dst = (state == REQ) ? held_dst : '0;
    assign drop    = ~rst && (state == IDLE) && valid && (~|dst || ~|len);
    assign pop     = (state == XFER) || drop;
    assign done    = (state == XFER) && (beat_cnt == LEN_WIDTH'(1));
    assign starve  = (wait_cnt == WW'(MAX_WAIT));
endmodule

// File: rtl/xbar_xfer_ctrl.sv
// xbar_xfer_ctrl: per-input packet sequencer holding crossbar output locks for whole packets
// XBAR_XFER_STATS_EN adds per-input completed-packet counters (pkt_count, stats_clr)
module xbar_xfer_ctrl #(
    parameter int NUM_PORTS = packet_pkg::NUM_PORTS,
    parameter int LEN_WIDTH = packet_pkg::LEN_WIDTH,
    parameter int MAX_WAIT  = packet_pkg::MAX_WAIT
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef XBAR_XFER_STATS_EN
    input  logic                           stats_clr,
    output logic [NUM_PORTS*16-1:0]        pkt_count,
`endif
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_dst,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0] in_len,
    output logic [NUM_PORTS-1:0]           arb_req,
    output logic [NUM_PORTS*NUM_PORTS-1:0] arb_dst,
    input  logic [NUM_PORTS-1:0]           arb_grant,
    output logic [NUM_PORTS-1:0]           in_pop,
    output logic [NUM_PORTS-1:0]           out_busy,
    output logic [NUM_PORTS-1:0]           xfer_done,
    output logic [NUM_PORTS-1:0]           err_drop,
    output logic [NUM_PORTS-1:0]           starve
);
    logic [NUM_PORTS-1:0] lock_vec, grant, clash, done, drop, claim, rel;
    logic [NUM_PORTS-1:0] held [NUM_PORTS];
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        xfer_port_fsm #(
            .NUM_PORTS(NUM_PORTS),
            .LEN_WIDTH(LEN_WIDTH),
            .MAX_WAIT (MAX_WAIT)
        ) u_fsm (
            .clk     (clk),
            .rst     (rst),
            .valid   (in_valid[i]),
            .dst     (in_dst[i*NUM_PORTS +: NUM_PORTS]),
            .len     (in_len[i*LEN_WIDTH +: LEN_WIDTH]),
            .lock_vec(lock_vec),
            .grant   (grant[i]),
            .req     (arb_req[i]),
            .req_dst (arb_dst[i*NUM_PORTS +: NUM_PORTS]),
            .held_dst(held[i]),
            .pop     (in_pop[i]),
            .done    (done[i]),
            .drop    (drop[i]),
            .starve  (starve[i])
        );
    end
    // Lower indices claim outputs first; an overlapping later grant is an arbiter fault
    always_comb begin
        grant = '0;
        clash = '0;
        claim = '0;
        rel   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant[i] = arb_req[i] && arb_grant[i] && ~|(held[i] & claim);
            clash[i] = arb_req[i] && arb_grant[i] && !grant[i];
            claim   |= grant[i] ? held[i] : '0;
            rel     |= done[i] ? held[i] : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) lock_vec <= '0;
        else lock_vec <= (lock_vec & ~rel) | claim;
    end
    assign out_busy  = lock_vec;
    assign xfer_done = done;
    assign err_drop  = drop | clash;
`ifdef XBAR_XFER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            pkt_count <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (done[i]) pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule
